// File: rtl/if_id_stage_if.sv
// Handshake and data bundle between the IF stage, the IF/ID buffer and the ID stage.
// The slave view belongs to the buffer; the master view drives it (IF/ID pipeline or a testbench).
interface if_id_stage_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] npc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] instrout;
    logic [DATA_W-1:0] npcout;
    logic [1:0]        count;

    modport master (
        output flush, in_valid, instr, npc, out_ready,
        input  in_ready, out_valid, instrout, npcout, count
    );

    modport slave (
        input  flush, in_valid, instr, npc, out_ready,
        output in_ready, out_valid, instrout, npcout, count
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline buffer: a 2-entry in-order skid buffer whose in_ready depends only on
// registered occupancy, with a synchronous flush that squashes everything held.
module if_id_stage #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    if_id_stage_if.slave  bus
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] npc;
    } entry_t;

    // Occupancy doubles as the FSM state; encoding equals the count output.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept;
    logic   pop;

    assign in_entry = '{instr: bus.instr, npc: bus.npc};

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.count     = state_q;
    assign bus.instrout  = bus.out_valid ? head_q.instr : NOP_INSTR;
    assign bus.npcout    = bus.out_valid ? head_q.npc   : '0;

    assign accept = bus.in_valid  && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;

    // NOTE: state and payload take defaults first so every path assigns them and no latch is inferred.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the two payload registers are reset too, so no stale instruction survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the instruction and NPC fields.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0000 (sized DATA_W), meaning the instruction presented while no valid entry exists.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port flush, input, 1: synchronous squash of all held entries (taken branch/jump).
REQ-007 Port in_valid, input, 1: the IF stage presents instr/npc.
REQ-008 Port in_ready, output, 1: the block can accept an entry this cycle.
REQ-009 Port instr, input, DATA_W: fetched instruction.
REQ-010 Port npc, input, DATA_W: next PC for the fetched instruction.
REQ-011 Port out_valid, output, 1: instrout/npcout hold a valid entry.
REQ-012 Port out_ready, input, 1: the ID stage consumes the head entry this cycle.
REQ-013 Port instrout, output, DATA_W: head-entry instruction.
REQ-014 Port npcout, output, DATA_W: head-entry NPC.
REQ-015 Port count, output, 2: number of held entries, 0..2.

Function
REQ-016 Storage SHALL be a 2-entry in-order buffer (head register plus skid register) so that in_ready depends only on state, never combinationally on out_ready.
REQ-017 in_ready SHALL be 1 when count<2 and 0 when count==2; flush SHALL NOT affect in_ready in the same cycle.
REQ-018 Accept SHALL occur at a rising edge where in_valid && in_ready; pop SHALL occur at a rising edge where out_valid && out_ready.
REQ-019 out_valid SHALL equal (count!=0), registered; it SHALL NOT be a combinational function of inputs.
REQ-020 When out_valid==0, instrout SHALL be NOP_INSTR and npcout SHALL be 0.
REQ-021 Latency: an entry accepted into an empty block SHALL appear on instrout/npcout with out_valid=1 on the cycle after the accepting edge.
REQ-022 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush.
REQ-023 Transition count 0, accept -> 1 (new entry becomes head).
REQ-024 Transition count 1, accept without pop -> 2 (new entry goes to skid); pop without accept -> 0; accept with pop -> 1 with new entry as head.
REQ-025 Transition count 2, pop -> 1 with skid entry moved to head; accept is impossible (in_ready=0).
REQ-026 Data registers SHALL hold value while their entry is held and out_ready==0 (stall); head SHALL be stable throughout a stall.
REQ-027 Flush SHALL have priority over accept and pop: at a flush edge, count becomes 0, both entries invalidate, any same-cycle input is discarded, and any same-cycle pop is still considered completed by ID.
REQ-028 After a flush edge, out_valid SHALL be 0 and instrout SHALL be NOP_INSTR on the next cycle; acceptance resumes at the following edge if in_valid.
REQ-029 count SHALL never exceed 2 or underflow below 0.

Reset
REQ-030 On rst_n=0, regardless of clk: count=0, out_valid=0, instrout=NOP_INSTR, npcout=0, in_ready=1, both storage registers cleared.
REQ-031 Reset asserted mid-stall or mid-transfer SHALL discard all entries; the first edge after rst_n rises SHALL behave as from count=0.

Verification
REQ-032 Reset: rst_n=0 asynchronously with count=2 -> immediately out_valid=0, instrout=0, npcout=0, count=0, in_ready=1.
REQ-033 Passthrough: out_ready=1, stream instr A1..A4 with npc 4,8,12,16 on consecutive cycles -> each appears 1 cycle later in order, count stays 1, in_ready stays 1.
REQ-034 Stall fill: out_ready=0, present B1 (npc 0x100), B2 (npc 0x104), B3 -> B1,B2 accepted, count=2, in_ready=0, B3 held off; instrout=B1 stable; then out_ready=1 -> B1, B2, B3 emerge in order with none lost.
REQ-035 Flush priority: count=2 with C1,C2 held, flush=1, in_valid=1 with C3, out_ready=1 on the same edge -> next cycle count=0, out_valid=0, instrout=NOP_INSTR; C3 never appears.
REQ-036 Simultaneous accept/pop at count=1: head D1, present D2 with out_ready=1 -> next cycle instrout=D2, count=1.
REQ-037 Randomised valid/ready with a scoreboard over 10,000 cycles, DATA_W=16 -> order preserved, count in 0..2, no loss except at flush edges.
